// File: rtl/gcd_iter.sv
`default_nettype none
// ============================================================================
// Module   : gcd_iter
// Brief    : Iterative GCD engine (subtractive Euclid or binary Stein) with
//            start/idle/done handshake and a saturating iteration counter.
// Revision : 1.0
// ============================================================================
module gcd_iter #(
    parameter int WIDTH  = 32,
    parameter int ALGO   = 0,
    parameter int ITER_W = 16
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              start,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    output logic [WIDTH-1:0]  return_val,
    output logic              idle,
    output logic              done,
    output logic [ITER_W-1:0] iter_cnt
);

    localparam int K_W = $clog2(WIDTH) + 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'b001,
        S_CAL  = 3'b010,
        S_DONE = 3'b100
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_x;
    logic [WIDTH-1:0]   r_y;
    logic [K_W-1:0]     r_k;
    logic [ITER_W-1:0]  r_cnt;
    logic [WIDTH-1:0]   r_ret;
    logic [ITER_W-1:0]  r_iter;

    logic [WIDTH-1:0]   w_x_next;
    logic [WIDTH-1:0]   w_y_next;
    logic [K_W-1:0]     w_k_next;
    logic [WIDTH-1:0]   w_sub_xy;
    logic [WIDTH-1:0]   w_sub_yx;
    logic               w_zero;
    logic               w_term;
    logic [WIDTH-1:0]   w_result;
    logic [ITER_W-1:0]  w_cnt_inc;

    assign idle       = (r_state == S_IDLE);
    assign done       = (r_state == S_DONE);
    assign return_val = r_ret;
    assign iter_cnt   = r_iter;

    // Subtractions are only consumed in the larger-minus-smaller direction.
    assign w_sub_xy  = r_x - r_y;
    assign w_sub_yx  = r_y - r_x;
    assign w_zero    = (r_x == '0) || (r_y == '0);
    assign w_term    = w_zero || (r_x == r_y);
    assign w_result  = w_zero ? (r_x | r_y) : (r_x << r_k);
    assign w_cnt_inc = (&r_cnt) ? r_cnt : (r_cnt + ITER_W'(1));

    generate
        if (ALGO == 0) begin : g_euclid
            always_comb begin
                w_x_next = r_x;
                w_y_next = r_y;
                w_k_next = r_k;
                if (r_x > r_y) begin
                    w_x_next = w_sub_xy;
                end else begin
                    w_y_next = w_sub_yx;
                end
            end
        end else begin : g_stein
            always_comb begin
                w_x_next = r_x;
                w_y_next = r_y;
                w_k_next = r_k;
                if (!r_x[0] && !r_y[0]) begin
                    w_x_next = r_x >> 1;
                    w_y_next = r_y >> 1;
                    w_k_next = r_k + K_W'(1);
                end else if (!r_x[0]) begin
                    w_x_next = r_x >> 1;
                end else if (!r_y[0]) begin
                    w_y_next = r_y >> 1;
                end else if (r_x > r_y) begin
                    w_x_next = w_sub_xy >> 1;
                end else begin
                    w_y_next = w_sub_yx >> 1;
                end
            end
        end
    endgenerate

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE:  if (start)  w_state_next = S_CAL;
            S_CAL:   if (w_term) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_x    <= '0;
            r_y    <= '0;
            r_k    <= '0;
            r_cnt  <= '0;
            r_ret  <= '0;
            r_iter <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_x   <= a;
                        r_y   <= b;
                        r_k   <= '0;
                        r_cnt <= '0;
                    end
                end
                S_CAL: begin
                    r_cnt <= w_cnt_inc;
                    if (w_term) begin
                        r_ret  <= w_result;
                        r_iter <= w_cnt_inc;
                    end else begin
                        r_x <= w_x_next;
                        r_y <= w_y_next;
                        r_k <= w_k_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gcd_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_gcd_iter
// Brief    : Self-checking bench for gcd_iter across four parameter sets.
// Revision : 1.0
// ============================================================================
module tb_gcd_iter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        st  [4];
    logic [15:0] aa  [4];
    logic [15:0] bb  [4];
    logic [15:0] rv  [4];
    logic [15:0] ic  [4];
    logic        idl [4];
    logic        dn  [4];
    logic [7:0]  rv2, rv3;
    logic [15:0] ic2;
    logic [3:0]  ic3;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    // 0: W16 Euclid, 1: W16 Stein, 2: W8 Euclid, 3: W8 Euclid with 4-bit counter
    gcd_iter #(.WIDTH(16), .ALGO(0), .ITER_W(16)) u0 (
        .sys_clk(clk), .sys_rst_n(rst_n), .start(st[0]), .a(aa[0]), .b(bb[0]),
        .return_val(rv[0]), .idle(idl[0]), .done(dn[0]), .iter_cnt(ic[0]));
    gcd_iter #(.WIDTH(16), .ALGO(1), .ITER_W(16)) u1 (
        .sys_clk(clk), .sys_rst_n(rst_n), .start(st[1]), .a(aa[1]), .b(bb[1]),
        .return_val(rv[1]), .idle(idl[1]), .done(dn[1]), .iter_cnt(ic[1]));
    gcd_iter #(.WIDTH(8), .ALGO(0), .ITER_W(16)) u2 (
        .sys_clk(clk), .sys_rst_n(rst_n), .start(st[2]), .a(aa[2][7:0]), .b(bb[2][7:0]),
        .return_val(rv2), .idle(idl[2]), .done(dn[2]), .iter_cnt(ic2));
    gcd_iter #(.WIDTH(8), .ALGO(0), .ITER_W(4)) u3 (
        .sys_clk(clk), .sys_rst_n(rst_n), .start(st[3]), .a(aa[3][7:0]), .b(bb[3][7:0]),
        .return_val(rv3), .idle(idl[3]), .done(dn[3]), .iter_cnt(ic3));

    assign rv[2] = {8'h00, rv2};
    assign rv[3] = {8'h00, rv3};
    assign ic[2] = ic2;
    assign ic[3] = {12'h000, ic3};

    function automatic int algo_of(int i);
        return (i == 1) ? 1 : 0;
    endfunction

    function automatic int iter_max(int i);
        return (i == 3) ? 15 : 65535;
    endfunction

    function automatic int unsigned op_mask(int i, logic [15:0] v);
        return (i >= 2) ? int'(v[7:0]) : int'(v);
    endfunction

    // Reference gcd via remainder Euclid, independent of either hardware algorithm.
    function automatic int unsigned ref_gcd(int unsigned x, int unsigned y);
        int unsigned t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic int ref_steps(int algo, int unsigned x, int unsigned y);
        int n = 0;
        forever begin
            n++;
            if (x == 0 || y == 0 || x == y) return n;
            if (algo == 0) begin
                if (x > y) x = x - y; else y = y - x;
            end else if (x % 2 == 0 && y % 2 == 0) begin
                x = x / 2; y = y / 2;
            end else if (x % 2 == 0) begin
                x = x / 2;
            end else if (y % 2 == 0) begin
                y = y / 2;
            end else if (x > y) begin
                x = (x - y) / 2;
            end else begin
                y = (y - x) / 2;
            end
        end
    endfunction

    task automatic chk(string name, int inst, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[u%0d]: got %0d expected %0d", name, inst, act, exp);
        end
    endtask

    // Behavioural model: accepted start -> busy for N cycles -> one done cycle.
    logic        m_busy [4];
    logic        m_done [4];
    int          m_rem  [4];
    logic [31:0] m_ret  [4];
    logic [31:0] m_iter [4];
    logic [31:0] p_ret  [4];
    logic [31:0] p_iter [4];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                m_busy[i] <= 1'b0; m_done[i] <= 1'b0; m_rem[i] <= 0;
                m_ret[i]  <= '0;   m_iter[i] <= '0;
                p_ret[i]  <= '0;   p_iter[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (m_done[i]) begin
                    m_done[i] <= 1'b0;
                end else if (m_busy[i]) begin
                    m_rem[i] <= m_rem[i] - 1;
                    if (m_rem[i] == 1) begin
                        m_busy[i] <= 1'b0;
                        m_done[i] <= 1'b1;
                        m_ret[i]  <= p_ret[i];
                        m_iter[i] <= p_iter[i];
                    end
                end else if (st[i]) begin
                    m_busy[i] <= 1'b1;
                    m_rem[i]  <= ref_steps(algo_of(i), op_mask(i, aa[i]), op_mask(i, bb[i]));
                    p_ret[i]  <= ref_gcd(op_mask(i, aa[i]), op_mask(i, bb[i]));
                    p_iter[i] <= (ref_steps(algo_of(i), op_mask(i, aa[i]), op_mask(i, bb[i])) > iter_max(i))
                                 ? iter_max(i)
                                 : ref_steps(algo_of(i), op_mask(i, aa[i]), op_mask(i, bb[i]));
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            for (int i = 0; i < 4; i++) begin
                chk("idle", i, {31'd0, idl[i]}, {31'd0, !(m_busy[i] || m_done[i])});
                chk("done", i, {31'd0, dn[i]}, {31'd0, m_done[i]});
                chk("return_val", i, {16'd0, rv[i]}, m_ret[i]);
                chk("iter_cnt", i, {16'd0, ic[i]}, m_iter[i]);
            end
        end
    end

    // One operation with hand-supplied expectations; optional stray starts while busy.
    task automatic run_op(int i, logic [15:0] x, logic [15:0] y,
                          logic [31:0] e_ret, logic [31:0] e_iter, int e_low, bit poke);
        int          cnt   = 0;
        int          ndone = 0;
        logic [31:0] got_r = '0;
        logic [31:0] got_i = '0;
        @(negedge clk);
        st[i] = 1'b1; aa[i] = x; bb[i] = y;
        @(negedge clk);
        st[i] = 1'b0;
        while (idl[i] !== 1'b1 && cnt < 1000) begin
            if (dn[i] === 1'b1) begin
                ndone++;
                got_r = {16'd0, rv[i]};
                got_i = {16'd0, ic[i]};
            end
            if (poke && (cnt == 2 || dn[i] === 1'b1)) begin
                st[i] = 1'b1; aa[i] = x + 16'd3; bb[i] = y + 16'd1;
            end else begin
                st[i] = 1'b0;
            end
            cnt++;
            @(negedge clk);
        end
        st[i] = 1'b0;
        chk("done_count", i, ndone, 1);
        chk("op_result", i, got_r, e_ret);
        chk("op_iter", i, got_i, e_iter);
        chk("idle_low_cycles", i, cnt, e_low);
    endtask

    task automatic random_run(int i);
        int unsigned g, p, q, x, y, n;
        for (int r = 0; r < 1000; r++) begin
            g = $urandom_range(1, 1023);
            p = $urandom_range(0, 63);
            q = $urandom_range(0, 63);
            x = g * p;
            y = g * q;
            n = ref_steps(algo_of(i), x, y);
            run_op(i, x[15:0], y[15:0], ref_gcd(x, y), n, int'(n) + 1, 1'b0);
        end
    endtask

    initial begin
        #950000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] zx [4];
        logic [15:0] zy [4];
        logic [15:0] zr [4];
        zx = '{16'd0, 16'd0, 16'd9, 16'd5};
        zy = '{16'd0, 16'd7, 16'd0, 16'd5};
        zr = '{16'd0, 16'd7, 16'd9, 16'd5};
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            st[i] = 1'b0; aa[i] = '0; bb[i] = '0;
        end
        #23 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_idle", 0, {31'd0, idl[0]}, 1);
        chk("reset_done", 0, {31'd0, dn[0]}, 0);
        chk("reset_ret", 0, {16'd0, rv[0]}, 0);
        chk("reset_iter", 0, {16'd0, ic[0]}, 0);

        run_op(0, 16'd48, 16'd18, 6, 5, 6, 1'b0);
        run_op(1, 16'd48, 16'd18, 6, 6, 7, 1'b0);
        for (int z = 0; z < 4; z++) begin
            run_op(0, zx[z], zy[z], {16'd0, zr[z]}, 1, 2, 1'b0);
            run_op(1, zx[z], zy[z], {16'd0, zr[z]}, 1, 2, 1'b0);
        end
        run_op(2, 16'd255, 16'd1, 1, 255, 256, 1'b0);
        run_op(3, 16'd255, 16'd1, 1, 15, 256, 1'b0);
        run_op(0, 16'd48, 16'd18, 6, 5, 6, 1'b1);

        // Asynchronous reset in the middle of a long operation.
        @(negedge clk);
        st[0] = 1'b1; aa[0] = 16'd1000; bb[0] = 16'd1;
        @(negedge clk);
        st[0] = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_idle", 0, {31'd0, idl[0]}, 1);
        chk("async_rst_done", 0, {31'd0, dn[0]}, 0);
        chk("async_rst_ret", 0, {16'd0, rv[0]}, 0);
        chk("async_rst_iter", 0, {16'd0, ic[0]}, 0);
        @(negedge clk);
        #3 rst_n = 1'b1;
        run_op(0, 16'd48, 16'd18, 6, 5, 6, 1'b0);

        fork
            random_run(0);
            random_run(1);
        join

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
